seg_scan_mux: RTL and testbench

Time-multiplexed driver for an NDIG-digit common-anode/cathode 7-segment display. It holds an NDIG-nibble display word in a tear-free shadow register and scans one digit per DIV clock cycles. Each nibble is decoded to hex glyphs 0-F, with per-digit decimal points, leading-zero suppression and an anti-ghosting blank gap. It sits between the numeric datapath (counters, ALU results) and the board display pins.

---
 rtl/seg_scan_mux.sv | 236 +++++++++++++++++++++++
 tb/tb_seg_scan_mux.sv | 200 ++++++++++++++++++++
 2 files changed

// File: rtl/seg_scan_mux.sv
`default_nettype none
// ============================================================================
//  Module   : seg_scan_mux
//  Purpose  : Time-multiplexed NDIG-digit 7-segment display driver.
//             Captures a display word into a stage register, commits it to a
//             tear-free shadow register at frame boundaries, and scans one
//             digit per DIV clock cycles. Each digit shows a hex glyph,
//             optional decimal point, optional leading-zero suppression,
//             and an anti-ghosting blank gap at the start of every slot.
//  Ports    : clk      - system clock, rising edge
//             rst_n    - asynchronous active-low reset
//             value    - display word, nibble i drives digit i
//             dp_in    - decimal point per digit
//             load     - capture value/dp_in this cycle
//             lz_blank - enable leading-zero suppression
//             en       - display enable
//             seg      - segments {a,b,c,d,e,f,g} (registered)
//             dp       - decimal point segment (registered)
//             an       - digit selects, one-hot when active (registered)
//             frame    - one-cycle pulse after each full scan (registered)
//             pending  - captured word waiting for frame boundary
//  Revision : 1.0 - initial release
// ============================================================================
module seg_scan_mux #(
  parameter int NDIG           = 4,
  parameter int DIV            = 50000,
  parameter int BLANK          = 2,
  parameter bit SEG_ACTIVE_LOW = 1'b0,
  parameter bit DIG_ACTIVE_LOW = 1'b1
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic [4*NDIG-1:0] value,
  input  logic [NDIG-1:0]   dp_in,
  input  logic              load,
  input  logic              lz_blank,
  input  logic              en,
  output logic [6:0]        seg,
  output logic              dp,
  output logic [NDIG-1:0]   an,
  output logic              frame,
  output logic              pending
);

  localparam int CW = (DIV  > 1) ? $clog2(DIV)  : 1;
  localparam int IW = (NDIG > 1) ? $clog2(NDIG) : 1;

  localparam logic [CW-1:0]   C_CNT_MAX = CW'(DIV - 1);
  localparam logic [IW-1:0]   C_IDX_MAX = IW'(NDIG - 1);
  localparam logic [6:0]      C_SEG_OFF = {7{SEG_ACTIVE_LOW}};
  localparam logic            C_DP_OFF  = SEG_ACTIVE_LOW;
  localparam logic [NDIG-1:0] C_AN_OFF  = {NDIG{DIG_ACTIVE_LOW}};

  // Hex glyph table, active-high, bit order {a,b,c,d,e,f,g}.
  function automatic logic [6:0] f_glyph(input logic [3:0] nib);
    logic [6:0] g;
    case (nib)
      4'h0: g = 7'b1111110;
      4'h1: g = 7'b0110000;
      4'h2: g = 7'b1101101;
      4'h3: g = 7'b1111001;
      4'h4: g = 7'b0110011;
      4'h5: g = 7'b1011011;
      4'h6: g = 7'b1011111;
      4'h7: g = 7'b1110000;
      4'h8: g = 7'b1111111;
      4'h9: g = 7'b1111011;
      4'hA: g = 7'b1110111;
      4'hB: g = 7'b0011111;
      4'hC: g = 7'b1001110;
      4'hD: g = 7'b0111101;
      4'hE: g = 7'b1001111;
      default: g = 7'b1000111;
    endcase
    return g;
  endfunction

  // --------------------------------------------------------------------------
  // State
  // --------------------------------------------------------------------------
  logic [CW-1:0]     cnt_q,       cnt_d;
  logic [IW-1:0]     idx_q,       idx_d;
  logic [4*NDIG-1:0] stage_q,     stage_d;
  logic [NDIG-1:0]   stage_dp_q,  stage_dp_d;
  logic [4*NDIG-1:0] shadow_q,    shadow_d;
  logic [NDIG-1:0]   shadow_dp_q, shadow_dp_d;
  logic              pending_q,   pending_d;
  logic [6:0]        seg_q,       seg_d;
  logic              dp_q,        dp_d;
  logic [NDIG-1:0]   an_q,        an_d;
  logic              frame_q,     frame_d;

  // --------------------------------------------------------------------------
  // Scan counters and capture/commit
  // --------------------------------------------------------------------------
  logic w_cnt_wrap;
  logic w_tick;
  logic w_commit;

  always_comb begin
    w_cnt_wrap = (cnt_q == C_CNT_MAX);
    w_tick     = w_cnt_wrap && (idx_q == C_IDX_MAX);
    w_commit   = w_tick && (pending_q || load);

    cnt_d = w_cnt_wrap ? '0 : cnt_q + CW'(1);
    idx_d = idx_q;
    if (w_cnt_wrap) begin
      idx_d = (idx_q == C_IDX_MAX) ? '0 : idx_q + IW'(1);
    end

    stage_d    = load ? value : stage_q;
    stage_dp_d = load ? dp_in : stage_dp_q;

    // A load landing on the frame tick bypasses the stage so it is shown
    // from the very next frame without ever raising pending.
    shadow_d    = shadow_q;
    shadow_dp_d = shadow_dp_q;
    if (w_commit) begin
      shadow_d    = load ? value : stage_q;
      shadow_dp_d = load ? dp_in : stage_dp_q;
    end

    if (w_commit) begin
      pending_d = 1'b0;
    end else if (load) begin
      pending_d = 1'b1;
    end else begin
      pending_d = pending_q;
    end
  end

  // --------------------------------------------------------------------------
  // Blank gap at the start of each slot
  // --------------------------------------------------------------------------
  logic w_gap;

  generate
    if (BLANK == 0) begin : g_no_gap
      assign w_gap = 1'b0;
    end else begin : g_gap
      localparam logic [CW-1:0] C_BLANK = CW'(BLANK);
      assign w_gap = (cnt_q < C_BLANK);
    end
  endgenerate

  // --------------------------------------------------------------------------
  // Leading-zero suppression: walk from the top digit down; a digit is
  // suppressed while every nibble at or above it is zero with no dp set.
  // --------------------------------------------------------------------------
  logic [NDIG-1:0] w_supp;

  always_comb begin
    logic v_run;
    v_run  = lz_blank;
    w_supp = '0;
    for (int i = NDIG - 1; i >= 0; i--) begin
      v_run = v_run && (shadow_q[4*i +: 4] == 4'h0) && !shadow_dp_q[i];
      if (i != 0) begin
        w_supp[i] = v_run;
      end
    end
  end

  // --------------------------------------------------------------------------
  // Current-digit selection and output decode
  // --------------------------------------------------------------------------
  logic [3:0]      w_nib;
  logic            w_dp_bit;
  logic            w_sel_supp;
  logic            w_lit;
  logic [NDIG-1:0] w_an_oh;

  always_comb begin
    w_nib      = 4'h0;
    w_dp_bit   = 1'b0;
    w_sel_supp = 1'b0;
    for (int i = 0; i < NDIG; i++) begin
      if (idx_q == IW'(i)) begin
        w_nib      = shadow_q[4*i +: 4];
        w_dp_bit   = shadow_dp_q[i];
        w_sel_supp = w_supp[i];
      end
    end

    w_lit = en && !w_gap && !w_sel_supp;

    w_an_oh = '0;
    for (int i = 0; i < NDIG; i++) begin
      w_an_oh[i] = w_lit && (idx_q == IW'(i));
    end

    seg_d   = (w_lit ? f_glyph(w_nib) : 7'b0000000) ^ C_SEG_OFF;
    dp_d    = (w_lit && w_dp_bit) ^ C_DP_OFF;
    an_d    = w_an_oh ^ C_AN_OFF;
    frame_d = w_tick;
  end

  // --------------------------------------------------------------------------
  // Registers
  // --------------------------------------------------------------------------
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      cnt_q       <= '0;
      idx_q       <= '0;
      stage_q     <= '0;
      stage_dp_q  <= '0;
      shadow_q    <= '0;
      shadow_dp_q <= '0;
      pending_q   <= 1'b0;
      seg_q       <= C_SEG_OFF;
      dp_q        <= C_DP_OFF;
      an_q        <= C_AN_OFF;
      frame_q     <= 1'b0;
    end else begin
      cnt_q       <= cnt_d;
      idx_q       <= idx_d;
      stage_q     <= stage_d;
      stage_dp_q  <= stage_dp_d;
      shadow_q    <= shadow_d;
      shadow_dp_q <= shadow_dp_d;
      pending_q   <= pending_d;
      seg_q       <= seg_d;
      dp_q        <= dp_d;
      an_q        <= an_d;
      frame_q     <= frame_d;
    end
  end

  assign seg     = seg_q;
  assign dp      = dp_q;
  assign an      = an_q;
  assign frame   = frame_q;
  assign pending = pending_q;

endmodule
`default_nettype wire

// File: tb/tb_seg_scan_mux.sv
`default_nettype none
// ============================================================================
//  Module   : tb_seg_scan_mux
//  Purpose  : Self-checking bench for seg_scan_mux (NDIG=4, DIV=4, BLANK=1,
//             active-high segments, active-low anodes). Expected outputs come
//             from a time-indexed reference model: slot position and digit
//             index are derived from the cycle count since reset.
//  Revision : 1.0 - initial release
// ============================================================================
module tb_seg_scan_mux;

  localparam int NDIG  = 4;
  localparam int DIV   = 4;
  localparam int BLANK = 1;

  logic              clk = 1'b0;
  logic              rst_n;
  logic [4*NDIG-1:0] value;
  logic [NDIG-1:0]   dp_in;
  logic              load;
  logic              lz_blank;
  logic              en;
  logic [6:0]        seg;
  logic              dp;
  logic [NDIG-1:0]   an;
  logic              frame;
  logic              pending;

  seg_scan_mux #(
    .NDIG(NDIG), .DIV(DIV), .BLANK(BLANK),
    .SEG_ACTIVE_LOW(1'b0), .DIG_ACTIVE_LOW(1'b1)
  ) dut (
    .clk(clk), .rst_n(rst_n), .value(value), .dp_in(dp_in), .load(load),
    .lz_blank(lz_blank), .en(en), .seg(seg), .dp(dp), .an(an),
    .frame(frame), .pending(pending)
  );

  always #5 clk = ~clk;

  int checks = 0;
  int errors = 0;

  // Reference model state
  int          m_t;          // cycles since reset release
  logic [15:0] m_stage;
  logic [3:0]  m_stage_dp;
  logic [15:0] m_shadow;
  logic [3:0]  m_shadow_dp;
  bit          m_pend;
  logic [6:0]  glyph [16];

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic model_reset();
    m_t = 0; m_stage = '0; m_stage_dp = '0;
    m_shadow = '0; m_shadow_dp = '0; m_pend = 0;
  endtask

  // One clock: predict outputs from the pre-edge model state, advance the
  // model, then compare after the edge.
  task automatic step();
    int         c, ix, n;
    bit         tick, supp, lit;
    logic [6:0] e_seg;
    logic       e_dp;
    logic [3:0] e_an;
    c    = m_t % DIV;
    ix   = (m_t / DIV) % NDIG;
    tick = (c == DIV - 1) && (ix == NDIG - 1);
    supp = lz_blank && ix > 0 && ((m_shadow >> (4 * ix)) == 0) && ((m_shadow_dp >> ix) == 0);
    lit  = en && (c >= BLANK) && !supp;
    n    = (m_shadow >> (4 * ix)) & 15;
    e_seg = lit ? glyph[n] : 7'b0000000;
    e_dp  = lit ? m_shadow_dp[ix] : 1'b0;
    e_an  = lit ? ~(4'b0001 << ix) : 4'b1111;
    if (tick && (m_pend || load)) begin
      m_shadow    = load ? value : m_stage;
      m_shadow_dp = load ? dp_in : m_stage_dp;
      m_pend      = 0;
    end else if (load) begin
      m_pend = 1;
    end
    if (load) begin
      m_stage = value; m_stage_dp = dp_in;
    end
    m_t++;
    @(posedge clk);
    #1;
    chk("seg", {25'd0, seg}, {25'd0, e_seg});
    chk("dp", {31'd0, dp}, {31'd0, e_dp});
    chk("an", {28'd0, an}, {28'd0, e_an});
    chk("frame", {31'd0, frame}, {31'd0, tick});
    chk("pending", {31'd0, pending}, {31'd0, m_pend});
  endtask

  task automatic run(input int n);
    for (int i = 0; i < n; i++) step();
  endtask

  task automatic do_load(input logic [15:0] v, input logic [3:0] d);
    value = v; dp_in = d; load = 1'b1;
    step();
    load = 1'b0;
  endtask

  initial begin
    glyph = '{7'b1111110, 7'b0110000, 7'b1101101, 7'b1111001,
              7'b0110011, 7'b1011011, 7'b1011111, 7'b1110000,
              7'b1111111, 7'b1111011, 7'b1110111, 7'b0011111,
              7'b1001110, 7'b0111101, 7'b1001111, 7'b1000111};
    rst_n = 1'b0; value = '0; dp_in = '0; load = 1'b0; lz_blank = 1'b0; en = 1'b1;
    model_reset();
    repeat (3) @(posedge clk);
    #1;
    chk("rst_seg", {25'd0, seg}, 32'h0);
    chk("rst_an", {28'd0, an}, 32'hF);
    chk("rst_frame", {31'd0, frame}, 32'h0);
    chk("rst_pending", {31'd0, pending}, 32'h0);
    rst_n = 1'b1;

    // Basic word with hex digits
    do_load(16'h1234, 4'b0000);
    run(40);

    // Leading-zero suppression, then a dp that keeps upper digits lit
    lz_blank = 1'b1;
    do_load(16'h0070, 4'b0000);
    run(36);
    do_load(16'h0070, 4'b1000);
    run(36);
    do_load(16'h0000, 4'b0000);
    run(20);
    lz_blank = 1'b0;

    // Last write wins between frame boundaries
    while ((m_t % 16) != 3) step();
    do_load(16'hAAAA, 4'b0000);
    run(3);
    do_load(16'hBBBB, 4'b0101);
    run(36);

    // Load coincident with the frame tick
    while ((m_t % 16) != 15) step();
    do_load(16'hC0DE, 4'b0010);
    run(20);

    // Display disabled for one frame, then resumed
    en = 1'b0;
    run(17);
    en = 1'b1;
    run(16);

    // Asynchronous reset while digit 2 is being scanned, with a capture pending
    do_load(16'h5A5A, 4'b1111);
    for (int k = 0; k < 64 && ((m_t / DIV) % NDIG) != 2; k++) step();
    chk("idx2_reached", ((m_t / DIV) % NDIG), 2);
    rst_n = 1'b0;
    #1;
    chk("arst_seg", {25'd0, seg}, 32'h0);
    chk("arst_dp", {31'd0, dp}, 32'h0);
    chk("arst_an", {28'd0, an}, 32'hF);
    chk("arst_pending", {31'd0, pending}, 32'h0);
    @(posedge clk);
    #1;
    rst_n = 1'b1;
    model_reset();
    run(40);

    // Randomized traffic
    for (int i = 0; i < 1500; i++) begin
      value    = 16'($urandom);
      dp_in    = 4'($urandom);
      if ($urandom_range(0, 7) == 0) lz_blank = ~lz_blank;
      if ($urandom_range(0, 29) == 0) en = ~en;
      load = ($urandom_range(0, 9) == 0);
      if ($urandom_range(0, 3) == 0 && load) value = {8'h00, value[7:0]};
      step();
      load = 1'b0;
    end

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

  initial begin
    #2000000;
    errors++;
    $display("FAIL timeout observed=running expected=finished");
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $fatal(1, "timeout");
  end

endmodule
`default_nettype wire
